pga_spi_writer: RTL and testbench

Responder end of the PGA set handshake. Accepts an 8-bit PGA gain code from the AFE gain controller via the set/ready handshake, serialises it as a 16-bit SPI mode-0 write frame to the PGA, then re-asserts ready. It sits between the AFE gain controller and the PGA's serial pins, and is write-only with no readback.

---
 rtl/afe_pkg.sv | 24 ++
 rtl/spi_half_period_timer.sv | 32 +++
 rtl/pga_spi_writer.sv | 153 +++++++++++++++
 tb/tb_pga_spi_writer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/afe_pkg.sv
// Shared AFE definitions: PGA code/frame widths, the SPI write-frame
// layout and the PGA SPI writer state encoding.
package afe_pkg;

    localparam int   PGA_CODE_W    = 8;
    localparam int   PGA_FRAME_W   = 16;
    localparam logic PGA_WRITE_BIT = 1'b0;

    typedef enum logic [2:0] {
        STARTUP  = 3'd0,
        IDLE     = 3'd1,
        CS_SETUP = 3'd2,
        SHIFT    = 3'd3,
        CS_HOLD  = 3'd4,
        GAP      = 3'd5
    } pga_spi_state_t;

    // Write frame sent MSB first: R/W bit, 7-bit register address, gain code.
    function automatic logic [PGA_FRAME_W-1:0] pga_frame(input logic [6:0]            addr,
                                                         input logic [PGA_CODE_W-1:0] code);
        return {PGA_WRITE_BIT, addr, code};
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// SCLK half-period timer: a loadable down-counter that emits a one-cycle
// tick every CLK_DIV clocks while enabled. Loading on i_start aligns the
// first tick to exactly CLK_DIV clocks after the start edge.
module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_en,
    output logic o_tick
);

    localparam int             CW     = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count down while enabled; reload on start and after each expiry.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= RELOAD;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - CW'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/pga_spi_writer.sv
// PGA SPI writer: accepts a gain code over the set/ready handshake and
// shifts it out as a 16-bit SPI mode-0 write frame, then re-arms ready.
// Every SPI phase (CS setup, each SCLK half, CS hold, deselect gap) lasts
// one timer tick, so a transfer is exactly 34 half-periods long.
module pga_spi_writer
    import afe_pkg::*;
#(
    parameter int         CLK_DIV        = 4,
    parameter logic [6:0] PGA_ADDR       = 7'h02,
    parameter int         STARTUP_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PGA_CODE_W-1:0] pga_code_i,
    input  logic                  set_pga_i,
    output logic                  pga_ready_o,
    output logic                  spi_cs_n_o,
    output logic                  spi_sclk_o,
    output logic                  spi_mosi_o
);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("pga_spi_writer: CLK_DIV must be >= 1");
    end
    if (STARTUP_CYCLES < 1) begin : g_bad_startup
        $error("pga_spi_writer: STARTUP_CYCLES must be >= 1");
    end

    localparam int            SU_W    = $clog2(STARTUP_CYCLES + 1);
    localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CYCLES - 1);

    pga_spi_state_t         r_state;
    logic                   r_ready;
    logic                   r_cs_n;
    logic                   r_sclk;
    logic                   r_mosi;
    logic [PGA_FRAME_W-2:0] r_shift;   // bits still to send after the one on MOSI
    logic [3:0]             r_bit;
    logic                   r_phase;   // 1 while SCLK is high within a bit
    logic [SU_W-1:0]        r_su_cnt;

    logic                   w_accept;
    logic                   w_busy;
    logic                   w_tick;
    logic [PGA_FRAME_W-1:0] w_frame;

    assign w_accept = set_pga_i && r_ready && (r_state == IDLE);
    assign w_busy   = (r_state == CS_SETUP) || (r_state == SHIFT) ||
                      (r_state == CS_HOLD)  || (r_state == GAP);
    assign w_frame  = pga_frame(PGA_ADDR, pga_code_i);

    spi_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_start (w_accept),
        .i_en    (w_busy),
        .o_tick  (w_tick)
    );

    // Transfer sequencer: startup delay, handshake accept, and one SPI phase per tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= STARTUP;
            r_ready  <= 1'b0;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_phase  <= 1'b0;
            r_su_cnt <= '0;
        end else begin
            case (r_state)
                STARTUP: begin
                    if (r_su_cnt == SU_LAST) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_su_cnt <= r_su_cnt + SU_W'(1);
                    end
                end
                IDLE: begin
                    // Frame is captured here so later code changes cannot leak in.
                    if (w_accept) begin
                        r_state <= CS_SETUP;
                        r_ready <= 1'b0;
                        r_cs_n  <= 1'b0;
                        r_mosi  <= w_frame[PGA_FRAME_W-1];
                        r_shift <= w_frame[PGA_FRAME_W-2:0];
                        r_bit   <= '0;
                        r_phase <= 1'b0;
                    end
                end
                CS_SETUP: begin
                    if (w_tick) begin
                        r_state <= SHIFT;
                        r_sclk  <= 1'b1;
                        r_phase <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (r_phase) begin
                            // Falling edge: present the next bit, or finish after bit 15
                            // leaving bit 0 on MOSI until CS rises.
                            r_sclk  <= 1'b0;
                            r_phase <= 1'b0;
                            if (r_bit == 4'd15) begin
                                r_state <= CS_HOLD;
                            end else begin
                                r_mosi  <= r_shift[PGA_FRAME_W-2];
                                r_shift <= {r_shift[PGA_FRAME_W-3:0], 1'b0};
                            end
                        end else begin
                            r_sclk  <= 1'b1;
                            r_phase <= 1'b1;
                            r_bit   <= r_bit + 4'd1;
                        end
                    end
                end
                CS_HOLD: begin
                    if (w_tick) begin
                        r_state <= GAP;
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= STARTUP;
                    r_ready  <= 1'b0;
                    r_cs_n   <= 1'b1;
                    r_sclk   <= 1'b0;
                    r_mosi   <= 1'b0;
                    r_su_cnt <= '0;
                end
            endcase
        end
    end

    assign pga_ready_o = r_ready;
    assign spi_cs_n_o  = r_cs_n;
    assign spi_sclk_o  = r_sclk;
    assign spi_mosi_o  = r_mosi;

endmodule

// File: tb/tb_pga_spi_writer.sv
// Directed bench for pga_spi_writer: one instance at the default divider
// and one at CLK_DIV=1. A passive monitor per instance records SCLK rises,
// the MOSI bit seen at each rise, CS low cycles and CS edges.
module tb_pga_spi_writer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, set0, ready0, cs0, sclk0, mosi0;
    logic [7:0] code0;
    logic       rst1, set1, ready1, cs1, sclk1, mosi1;
    logic [7:0] code1;

    int n_checks = 0;
    int n_err    = 0;

    pga_spi_writer u_dut (
        .clk         (clk),
        .rst         (rst0),
        .pga_code_i  (code0),
        .set_pga_i   (set0),
        .pga_ready_o (ready0),
        .spi_cs_n_o  (cs0),
        .spi_sclk_o  (sclk0),
        .spi_mosi_o  (mosi0)
    );

    pga_spi_writer #(.CLK_DIV(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst1),
        .pga_code_i  (code1),
        .set_pga_i   (set1),
        .pga_ready_o (ready1),
        .spi_cs_n_o  (cs1),
        .spi_sclk_o  (sclk1),
        .spi_mosi_o  (mosi1)
    );

    // Monitors: values seen at a posedge are those held during the previous cycle.
    int          rises0 = 0, frames0 = 0, cslow0 = 0;
    logic [15:0] cap0 = '0;
    logic        prev_sclk0 = 1'b0, prev_cs0 = 1'b1;
    always @(posedge clk) begin
        if (sclk0 && !prev_sclk0) begin
            rises0 <= rises0 + 1;
            cap0   <= {cap0[14:0], mosi0};
        end
        if (!cs0 && prev_cs0) frames0 <= frames0 + 1;
        if (!cs0) cslow0 <= cslow0 + 1;
        prev_sclk0 <= sclk0;
        prev_cs0   <= cs0;
    end

    int          rises1 = 0, frames1 = 0, cslow1 = 0, csrise1 = 0;
    logic [15:0] cap1 = '0;
    logic        prev_sclk1 = 1'b0, prev_cs1 = 1'b1;
    always @(posedge clk) begin
        if (sclk1 && !prev_sclk1) begin
            rises1 <= rises1 + 1;
            cap1   <= {cap1[14:0], mosi1};
        end
        if (!cs1 && prev_cs1) frames1 <= frames1 + 1;
        if (cs1 && !prev_cs1) csrise1 <= csrise1 + 1;
        if (!cs1) cslow1 <= cslow1 + 1;
        prev_sclk1 <= sclk1;
        prev_cs1   <= cs1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n, r0, f0, c0, r1, f1, c1, cr1;

        rst0 = 1'b0; rst1 = 1'b0; set0 = 1'b0; set1 = 1'b0; code0 = '0; code1 = '0;
        tick(); tick();
        chk("rst_ready", ready0, 0);
        chk("rst_cs_n",  cs0,    1);
        chk("rst_sclk",  sclk0,  0);
        chk("rst_mosi",  mosi0,  0);
        chk("rst_ready1", ready1, 0);

        // Startup: ready rises on the 16th edge after release
        rst0 = 1'b1; rst1 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                chk("su_ready_15", ready0, 0);
                chk("su_cs_n_15",  cs0,    1);
                chk("su_sclk_15",  sclk0,  0);
            end
        end
        chk("su_ready_16",  ready0, 1);
        chk("su_ready1_16", ready1, 1);

        // Single write of 8'hA5
        code0 = 8'hA5; set0 = 1'b1;
        r0 = rises0; f0 = frames0; c0 = cslow0;
        tick();
        chk("a5_ready_low", ready0, 0);
        chk("a5_cs_low",    cs0,    0);
        chk("a5_mosi_msb",  mosi0,  0);
        set0 = 1'b0;
        n = 0;
        while (!ready0 && n < 300) begin tick(); n++; end
        chk("a5_busy_cycles", n, 136);
        chk("a5_frame",       cap0, 16'h02A5);
        chk("a5_rises",       rises0 - r0, 16);
        chk("a5_cs_low_cyc",  cslow0 - c0, 132);
        chk("a5_one_write",   frames0 - f0, 1);
        chk("a5_cs_idle",     cs0,   1);
        chk("a5_mosi_idle",   mosi0, 0);

        // set held high, code changed mid-frame, then back-to-back accept
        code0 = 8'h10; set0 = 1'b1;
        f0 = frames0;
        tick();
        chk("b2b_ready_low", ready0, 0);
        for (int i = 0; i < 5; i++) tick();
        code0 = 8'h20;
        n = 5;
        while (!ready0 && n < 300) begin tick(); n++; end
        chk("b2b_busy1",  n, 136);
        chk("b2b_frame1", cap0, 16'h0210);
        chk("b2b_count1", frames0 - f0, 1);
        tick();
        chk("b2b_ready_pulse", ready0, 0);
        chk("b2b_cs_low2",     cs0,    0);
        set0 = 1'b0;
        n = 0;
        while (!ready0 && n < 300) begin tick(); n++; end
        chk("b2b_busy2",  n, 136);
        chk("b2b_frame2", cap0, 16'h0220);
        chk("b2b_count2", frames0 - f0, 2);

        // Reset mid-SHIFT while SCLK is high
        code0 = 8'h5A; set0 = 1'b1;
        tick();
        set0 = 1'b0;
        for (int i = 0; i < 45; i++) tick();
        chk("mid_sclk_high", sclk0, 1);
        chk("mid_cs_low",    cs0,   0);
        rst0 = 1'b0;
        tick();
        chk("mid_rst_cs_n",  cs0,    1);
        chk("mid_rst_sclk",  sclk0,  0);
        chk("mid_rst_ready", ready0, 0);
        chk("mid_rst_mosi",  mosi0,  0);
        rst0 = 1'b1;
        r0 = rises0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) chk("mid_su_ready_15", ready0, 0);
        end
        chk("mid_su_ready_16", ready0, 1);
        chk("mid_no_sclk",     rises0 - r0, 0);
        chk("mid_cs_idle",     cs0, 1);

        // One-cycle set pulse while busy is ignored
        code0 = 8'h33; set0 = 1'b1;
        f0 = frames0;
        tick();
        set0 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        set0 = 1'b1;
        tick();
        set0 = 1'b0;
        n = 10;
        while (!ready0 && n < 300) begin tick(); n++; end
        chk("ign_busy",  n, 136);
        chk("ign_frame", cap0, 16'h0233);
        for (int i = 0; i < 5; i++) tick();
        chk("ign_ready_held", ready0, 1);
        chk("ign_cs_idle",    cs0,    1);
        chk("ign_one_write",  frames0 - f0, 1);

        // CLK_DIV=1 instance, code 8'hFF
        code1 = 8'hFF; set1 = 1'b1;
        r1 = rises1; f1 = frames1; c1 = cslow1; cr1 = csrise1;
        tick();
        set1 = 1'b0;
        chk("d1_ready_low", ready1, 0);
        chk("d1_cs_low",    cs1,    0);
        tick();
        chk("d1_sclk_rise", sclk1, 1);
        tick();
        chk("d1_sclk_fall", sclk1, 0);
        n = 2;
        while (!ready1 && n < 100) begin tick(); n++; end
        chk("d1_busy",      n, 34);
        chk("d1_frame",     cap1, 16'h02FF);
        chk("d1_rises",     rises1 - r1, 16);
        chk("d1_cs_low_cyc", cslow1 - c1, 33);
        chk("d1_cs_falls",  frames1 - f1, 1);
        chk("d1_cs_rises",  csrise1 - cr1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
